wash_sequencer: RTL and testbench

Parametrised successor to the single-program washer FSM. Sequences FILL, then N x (WASH, RINSE), then SPIN, optional DRY, or a standalone STEAM program. Adds the following over the previous generation:
- per-phase durations set by parameters
- programmable wash count (1..MAX_WASHES)
- abort with a DRAIN phase
- program latching at start
- a phase/progress status interface

Sits between the front-panel input decoder and the motor/valve drivers.

---
 rtl/wash_pkg.sv | 52 +++++
 rtl/wash_phase_timer.sv | 45 ++++
 rtl/wash_sequencer.sv | 153 +++++++++++++++
 tb/tb_wash_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared phase encoding, duration table and wash-count clamp
// Purpose: types and helpers used by wash_sequencer and wash_phase_timer.
//   phase_t   : 3-bit phase/state encoding, also driven out on the phase port
//   dur_tbl_t : per-phase cycle counts, filled from the top-level parameters
//   dur_of    : duration of a phase (0 for IDLE); caller narrows to CNT_W
//   clamp_wc  : forces a requested wash count into 1..max_w
package wash_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4,
    PH_DRY   = 3'd5,
    PH_STEAM = 3'd6,
    PH_DRAIN = 3'd7
  } phase_t;

  typedef struct packed {
    logic [31:0] fill;
    logic [31:0] wash;
    logic [31:0] rinse;
    logic [31:0] spin;
    logic [31:0] dry;
    logic [31:0] steam;
    logic [31:0] drain;
  } dur_tbl_t;

  function automatic logic [31:0] dur_of(input phase_t ph, input dur_tbl_t tbl);
    case (ph)
      PH_FILL:  dur_of = tbl.fill;
      PH_WASH:  dur_of = tbl.wash;
      PH_RINSE: dur_of = tbl.rinse;
      PH_SPIN:  dur_of = tbl.spin;
      PH_DRY:   dur_of = tbl.dry;
      PH_STEAM: dur_of = tbl.steam;
      PH_DRAIN: dur_of = tbl.drain;
      default:  dur_of = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] clamp_wc(input logic [31:0] req, input logic [31:0] max_w);
    if (req == 32'd0)
      clamp_wc = 32'd1;
    else if (req > max_w)
      clamp_wc = max_w;
    else
      clamp_wc = req;
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// rtl/wash_phase_timer.sv - per-phase cycle timer with pause and end detect
// Purpose: counts cycles spent in the current phase.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : phase entry; timer restarts at 0 on this edge
//   en_i         : a timed phase is active (low in IDLE)
//   pause_i      : freezes the timer and suppresses end_o
//   dur_i        : duration of the current phase in cycles
//   end_o        : this edge ends the phase (timer at dur-1, not paused)
//   time_left_o  : dur-1-timer while enabled, 0 otherwise
module wash_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             pause_i,
  input  logic [CNT_W-1:0] dur_i,
  output logic             end_o,
  output logic [CNT_W-1:0] time_left_o
);

  logic [CNT_W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (load_i)
      timer_d = '0;
    else if (en_i && !pause_i)
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      timer_q <= '0;
    else
      timer_q <= timer_d;
  end

  // Pause outranks the end condition so a paused phase holds at its last cycle.
  assign end_o       = en_i && !pause_i && (timer_q == dur_i - 1'b1);
  assign time_left_o = en_i ? (dur_i - 1'b1 - timer_q) : '0;

endmodule

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - washer program sequencer (FILL, N x WASH/RINSE, SPIN, DRY / STEAM)
// Purpose: phase FSM plus wash counter between the front-panel decoder and the
//   motor/valve drivers.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start                   : level, sampled in IDLE only
//   wash_count, dry_en,
//   steam_mode              : program configuration, latched on start
//   pause                   : freezes the phase timer
//   abort                   : ends the program (via DRAIN for wet phases)
//   done / busy             : in IDLE / not in IDLE
//   phase                   : current phase encoding
//   wash_idx                : 1-based wash number in WASH/RINSE, else 0
//   time_left               : remaining cycles in the current phase
//   cycle_done              : one-cycle pulse on normal program completion
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int FILL_CYC   = 10,
  parameter int WASH_CYC   = 50,
  parameter int RINSE_CYC  = 50,
  parameter int SPIN_CYC   = 20,
  parameter int DRY_CYC    = 60,
  parameter int STEAM_CYC  = 60,
  parameter int DRAIN_CYC  = 15,
  parameter int MAX_WASHES = 3,
  parameter int WC_W       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WC_W-1:0]  wash_count,
  input  logic             dry_en,
  input  logic             steam_mode,
  input  logic             pause,
  input  logic             abort,
  output logic             done,
  output logic             busy,
  output logic [2:0]       phase,
  output logic [WC_W-1:0]  wash_idx,
  output logic [CNT_W-1:0] time_left,
  output logic             cycle_done
);

  localparam dur_tbl_t DURS = '{
    fill:  32'(FILL_CYC),  wash:  32'(WASH_CYC), rinse: 32'(RINSE_CYC),
    spin:  32'(SPIN_CYC),  dry:   32'(DRY_CYC),  steam: 32'(STEAM_CYC),
    drain: 32'(DRAIN_CYC)
  };

  phase_t           state_q, state_d;
  logic [WC_W-1:0]  wash_idx_q, wash_idx_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic             dry_q, dry_d;
  logic             cycle_done_q, cycle_done_d;
  logic [CNT_W-1:0] dur;
  logic             ph_end;

  assign dur = CNT_W'(dur_of(state_q, DURS));

  // Every transition is to a different state, so a state change marks entry.
  wash_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (state_d != state_q),
    .en_i        (state_q != PH_IDLE),
    .pause_i     (pause),
    .dur_i       (dur),
    .end_o       (ph_end),
    .time_left_o (time_left)
  );

  always_comb begin
    state_d      = state_q;
    wash_idx_d   = wash_idx_q;
    wc_d         = wc_q;
    dry_d        = dry_q;
    cycle_done_d = 1'b0;
    case (state_q)
      PH_IDLE: begin
        if (start) begin
          wc_d    = WC_W'(clamp_wc(32'(wash_count), 32'(MAX_WASHES)));
          dry_d   = dry_en;
          state_d = steam_mode ? PH_STEAM : PH_FILL;
        end
      end
      PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: begin
        if (abort) begin
          state_d    = PH_DRAIN;
          wash_idx_d = '0;
        end else if (ph_end) begin
          case (state_q)
            PH_FILL: begin
              state_d    = PH_WASH;
              wash_idx_d = WC_W'(1);
            end
            PH_WASH: state_d = PH_RINSE;
            PH_RINSE: begin
              if (wash_idx_q < wc_q) begin
                state_d    = PH_WASH;
                wash_idx_d = wash_idx_q + 1'b1;
              end else begin
                state_d    = PH_SPIN;
                wash_idx_d = '0;
              end
            end
            default: begin
              state_d      = dry_q ? PH_DRY : PH_IDLE;
              cycle_done_d = !dry_q;
            end
          endcase
        end
      end
      PH_DRY, PH_STEAM: begin
        // No water to drain here, so abort returns straight to IDLE.
        if (abort) begin
          state_d = PH_IDLE;
        end else if (ph_end) begin
          state_d      = PH_IDLE;
          cycle_done_d = 1'b1;
        end
      end
      default: begin
        if (ph_end)
          state_d = PH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PH_IDLE;
      wash_idx_q   <= '0;
      wc_q         <= '0;
      dry_q        <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wash_idx_q   <= wash_idx_d;
      wc_q         <= wc_d;
      dry_q        <= dry_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign phase      = state_q;
  assign done       = (state_q == PH_IDLE);
  assign busy       = ~done;
  assign wash_idx   = wash_idx_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - directed self-checking bench for wash_sequencer
module tb_wash_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] wash_count = 2'd0;
  logic       dry_en = 1'b0;
  logic       steam_mode = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;

  logic       done, busy, cycle_done;
  logic [2:0] phase;
  logic [1:0] wash_idx;
  logic [7:0] time_left;

  logic       done2, busy2, cycle_done2;
  logic [2:0] phase2;
  logic [1:0] wash_idx2;
  logic [7:0] time_left2;

  int nvec = 0;
  int nerr = 0;
  int n;
  int total;

  always #5 clk = ~clk;

  wash_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wash_count(wash_count),
    .dry_en(dry_en), .steam_mode(steam_mode), .pause(pause), .abort(abort),
    .done(done), .busy(busy), .phase(phase), .wash_idx(wash_idx),
    .time_left(time_left), .cycle_done(cycle_done)
  );

  wash_sequencer #(.MAX_WASHES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .wash_count(wash_count),
    .dry_en(dry_en), .steam_mode(steam_mode), .pause(pause), .abort(abort),
    .done(done2), .busy(busy2), .phase(phase2), .wash_idx(wash_idx2),
    .time_left(time_left2), .cycle_done(cycle_done2)
  );

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts edges until phase leaves ph; bounded so a stuck DUT cannot hang the run.
  task automatic measure(input logic [2:0] ph, output int cycles);
    cycles = 0;
    while (phase === ph && cycles < 1000) begin
      step(1);
      cycles++;
    end
  endtask

  task automatic do_start(input logic [1:0] wc, input logic dry, input logic steam);
    wash_count = wc; dry_en = dry; steam_mode = steam; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_done", done, 1);
    chk("rst_busy", busy, 0);
    chk("rst_phase", phase, 0);
    chk("rst_time_left", time_left, 0);
    chk("rst_wash_idx", wash_idx, 0);
    chk("rst_cycle_done", cycle_done, 0);
    rst_n = 1'b1;
    step(3);
    chk("idle_hold", phase, 0);

    // One wash with dry: 10/50/50/20/60 = 190
    do_start(2'd1, 1'b1, 1'b0);
    chk("t1_done_falls", done, 0);
    chk("t1_phase_fill", phase, 1);
    chk("t1_tl_fill", time_left, 9);
    total = 0;
    measure(3'd1, n); total += n; chk("t1_fill_len", n, 10);
    chk("t1_wash_idx", wash_idx, 1);
    chk("t1_tl_wash", time_left, 49);
    measure(3'd2, n); total += n; chk("t1_wash_len", n, 50);
    measure(3'd3, n); total += n; chk("t1_rinse_len", n, 50);
    chk("t1_spin_idx", wash_idx, 0);
    measure(3'd4, n); total += n; chk("t1_spin_len", n, 20);
    chk("t1_phase_dry", phase, 5);
    measure(3'd5, n); total += n; chk("t1_dry_len", n, 60);
    chk("t1_total", total, 190);
    chk("t1_idle", phase, 0);
    chk("t1_cdone", cycle_done, 1);
    step(1);
    chk("t1_cdone_off", cycle_done, 0);

    // Three washes, no dry; second instance clamps 3 to 2
    rst_n = 1'b0; step(1); rst_n = 1'b1; step(1);
    do_start(2'd3, 1'b0, 1'b0);
    total = 0;
    measure(3'd1, n); total += n;
    for (int k = 1; k <= 3; k++) begin
      chk("t2_wash_idx", wash_idx, k);
      if (k == 3) begin
        chk("t2_max2_spin", phase2, 4);
        chk("t2_max2_idx", wash_idx2, 0);
      end
      measure(3'd2, n); total += n; chk("t2_wash_len", n, 50);
      chk("t2_rinse_idx", wash_idx, k);
      measure(3'd3, n); total += n; chk("t2_rinse_len", n, 50);
    end
    chk("t2_spin_after3", phase, 4);
    measure(3'd4, n); total += n;
    chk("t2_total", total, 330);
    chk("t2_idle_no_dry", phase, 0);
    chk("t2_cdone", cycle_done, 1);

    // wash_count=0 acts as 1; pause mid-WASH and at time_left=0; abort+pause in SPIN
    step(1);
    do_start(2'd0, 1'b0, 1'b0);
    measure(3'd1, n);
    step(20);
    chk("t3_tl_pre", time_left, 29);
    pause = 1'b1;
    step(7);
    chk("t3_tl_paused", time_left, 29);
    chk("t3_phase_paused", phase, 2);
    pause = 1'b0;
    measure(3'd2, n);
    chk("t3_wash_len", 27 + n, 57);
    step(49);
    chk("t3_tl_zero", time_left, 0);
    pause = 1'b1;
    step(5);
    chk("t3_hold_end", phase, 3);
    chk("t3_hold_tl", time_left, 0);
    pause = 1'b0;
    step(1);
    chk("t3_wc0_spin", phase, 4);
    step(5);
    abort = 1'b1; pause = 1'b1;
    step(1);
    chk("t3_abort_pause", phase, 7);
    chk("t3_drain_tl", time_left, 14);
    abort = 1'b0; pause = 1'b0;
    measure(3'd7, n);
    chk("t3_drain_len", n, 15);
    chk("t3_no_cdone", cycle_done, 0);
    chk("t3_done", done, 1);

    // Abort in RINSE of wash 2
    do_start(2'd2, 1'b0, 1'b0);
    step(160);
    chk("t4_rinse2", phase, 3);
    chk("t4_rinse2_idx", wash_idx, 2);
    step(10);
    abort = 1'b1;
    step(1);
    chk("t4_drain", phase, 7);
    chk("t4_drain_idx", wash_idx, 0);
    abort = 1'b0;
    measure(3'd7, n);
    chk("t4_drain_len", n, 15);
    chk("t4_no_cdone", cycle_done, 0);

    // STEAM program, config changes ignored
    step(1);
    do_start(2'd1, 1'b0, 1'b1);
    chk("t5_steam", phase, 6);
    chk("t5_tl", time_left, 59);
    wash_count = 2'd3; dry_en = 1'b1; steam_mode = 1'b0;
    measure(3'd6, n);
    chk("t5_steam_len", n, 60);
    chk("t5_idle", phase, 0);
    chk("t5_cdone", cycle_done, 1);
    do_start(2'd1, 1'b0, 1'b1);
    step(30);
    abort = 1'b1;
    step(1);
    chk("t5_abort_idle", phase, 0);
    chk("t5_abort_cdone", cycle_done, 0);
    abort = 1'b0;

    // Asynchronous reset in SPIN
    do_start(2'd1, 1'b1, 1'b0);
    step(115);
    chk("t6_spin", phase, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_done", done, 1);
    chk("t6_async_phase", phase, 0);
    chk("t6_async_tl", time_left, 0);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("t6_post_idle", phase, 0);
    chk("t6_post_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
